// File: rtl/div_seq_restoring_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings,
// CLA slice size and the 8-bit carry-lookahead slice used by the subtractor.
package div_seq_restoring_pkg;

   localparam int CLA_SLICE = 8;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

   // One carry-lookahead slice: returns {carry_out, sum}.
   function automatic logic [CLA_SLICE:0] cla_slice_add(
      input logic [CLA_SLICE-1:0] a,
      input logic [CLA_SLICE-1:0] b,
      input logic                 cin
   );
      logic [CLA_SLICE-1:0] g;
      logic [CLA_SLICE-1:0] p;
      logic [CLA_SLICE:0]   c;
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      for (int i = 0; i < CLA_SLICE; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      return {c[CLA_SLICE], p ^ c[CLA_SLICE-1:0]};
   endfunction

endpackage

// File: rtl/div_seq_restoring_if.sv
// Start/operand/result bundle between the control stage (master) and the
// divider (slave).
interface div_seq_restoring_if #(
   parameter int WIDTH = 32
);
   logic             ctrl_DIV;
   logic [WIDTH-1:0] data_operandA;
   logic [WIDTH-1:0] data_operandB;
   logic [WIDTH-1:0] data_result;
   logic             data_exception;
   logic             data_resultRDY;
   logic             busy;

   modport master (
      output ctrl_DIV,
      output data_operandA,
      output data_operandB,
      input  data_result,
      input  data_exception,
      input  data_resultRDY,
      input  busy
   );

   modport slave (
      input  ctrl_DIV,
      input  data_operandA,
      input  data_operandB,
      output data_result,
      output data_exception,
      output data_resultRDY,
      output busy
   );
endinterface

// File: rtl/div_seq_restoring_sub_cla.sv
// N-bit subtractor a - b (a + ~b + 1) built from chained CLA slices plus a
// single-bit top stage. Operands are treated as unsigned; borrow_o=1 means
// a < b, i.e. the trial result is negative.
module div_seq_restoring_sub_cla
   import div_seq_restoring_pkg::*;
#(
   parameter int N = 33
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] diff_o,
   output logic         borrow_o
);

   localparam int NSLICE = (N - 1) / CLA_SLICE;

   logic [N-1:0]    b_inv_s;
   logic [NSLICE:0] carry_s;
   logic            top_p_s;
   logic            top_g_s;

   assign b_inv_s    = ~b_i;
   assign carry_s[0] = 1'b1;

   for (genvar s = 0; s < NSLICE; s++) begin : g_slice
      logic [CLA_SLICE:0] res_s;
      assign res_s = cla_slice_add(a_i[s*CLA_SLICE +: CLA_SLICE],
                                   b_inv_s[s*CLA_SLICE +: CLA_SLICE],
                                   carry_s[s]);
      assign diff_o[s*CLA_SLICE +: CLA_SLICE] = res_s[CLA_SLICE-1:0];
      assign carry_s[s+1] = res_s[CLA_SLICE];
   end

   // Top bit: one-bit stage so the width can be a slice multiple plus one.
   assign top_p_s     = a_i[N-1] ^ b_inv_s[N-1];
   assign top_g_s     = a_i[N-1] & b_inv_s[N-1];
   assign diff_o[N-1] = top_p_s ^ carry_s[NSLICE];
   assign borrow_o    = ~(top_g_s | (top_p_s & carry_s[NSLICE]));

endmodule

// File: rtl/div_seq_restoring.sv
// Multicycle signed restoring divider: one quotient bit per clock on
// magnitudes, sign fixed up afterwards. Divide-by-zero finishes at once
// with the exception flag raised.
module div_seq_restoring
   import div_seq_restoring_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                clock,
   input  logic                reset,
   div_seq_restoring_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int EXT_W = WIDTH + 1;

   div_state_e state_q, state_d;

   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;

   logic [WIDTH-1:0] result_q, result_d;
   logic             exc_q, exc_d;
   logic             rdy_q, rdy_d;
   logic             busy_q, busy_d;

   logic             accept_s;
   logic [EXT_W-1:0] neg_a_in_s;
   logic [EXT_W-1:0] neg_a_s;
   logic             neg_a_borrow_s;
   logic [EXT_W-1:0] neg_b_s;
   logic             b_nonzero_s;
   logic [WIDTH-1:0] abs_a_s;
   logic [WIDTH-1:0] abs_b_s;
   logic [EXT_W-1:0] rem_shift_s;
   logic [EXT_W-1:0] trial_s;
   logic             trial_borrow_s;
   logic             unused_bits_s;

   assign accept_s = bus.ctrl_DIV &&
                     ((state_q == DIV_IDLE) || (state_q == DIV_DONE));

   // One negator serves |A| at start and -Q during FIX; the states never overlap.
   assign neg_a_in_s = (state_q == DIV_FIX) ? {1'b0, q_q}
                     : {bus.data_operandA[WIDTH-1], bus.data_operandA};

   div_seq_restoring_sub_cla #(.N(EXT_W)) u_neg_a (
      .a_i      ({EXT_W{1'b0}}),
      .b_i      (neg_a_in_s),
      .diff_o   (neg_a_s),
      .borrow_o (neg_a_borrow_s)
   );

   // 0 - B borrows exactly when B is non-zero, which doubles as the zero test.
   div_seq_restoring_sub_cla #(.N(EXT_W)) u_neg_b (
      .a_i      ({EXT_W{1'b0}}),
      .b_i      ({bus.data_operandB[WIDTH-1], bus.data_operandB}),
      .diff_o   (neg_b_s),
      .borrow_o (b_nonzero_s)
   );

   // Magnitudes: the min value negates to 2^(WIDTH-1), still exact in WIDTH bits.
   assign abs_a_s = bus.data_operandA[WIDTH-1] ? neg_a_s[WIDTH-1:0] : bus.data_operandA;
   assign abs_b_s = bus.data_operandB[WIDTH-1] ? neg_b_s[WIDTH-1:0] : bus.data_operandB;

   assign rem_shift_s = {r_q, q_q[WIDTH-1]};

   div_seq_restoring_sub_cla #(.N(EXT_W)) u_trial (
      .a_i      (rem_shift_s),
      .b_i      ({1'b0, d_q}),
      .diff_o   (trial_s),
      .borrow_o (trial_borrow_s)
   );

   // Top bits that are provably zero or not needed by the datapath.
   assign unused_bits_s = ^{neg_a_borrow_s, neg_a_s[WIDTH], neg_b_s[WIDTH], trial_s[WIDTH]};

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= DIV_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: starts only accepted from IDLE/DONE, zero divisor short-cuts to DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         DIV_IDLE, DIV_DONE: begin
            if (bus.ctrl_DIV) begin
               state_d = b_nonzero_s ? DIV_RUN : DIV_DONE;
            end else begin
               state_d = DIV_IDLE;
            end
         end
         DIV_RUN: begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DIV_FIX;
            end else begin
               state_d = DIV_RUN;
            end
         end
         DIV_FIX: state_d = DIV_DONE;
         default: state_d = DIV_IDLE;
      endcase
   end

   // Datapath next state: operand capture on start, one restoring step per RUN cycle.
   always_comb begin
      r_d   = r_q;
      q_d   = q_q;
      d_d   = d_q;
      cnt_d = cnt_q;
      neg_d = neg_q;
      case (state_q)
         DIV_IDLE, DIV_DONE: begin
            if (accept_s && b_nonzero_s) begin
               r_d   = {WIDTH{1'b0}};
               q_d   = abs_a_s;
               d_d   = abs_b_s;
               cnt_d = {CNT_W{1'b0}};
               neg_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            end else begin
               cnt_d = cnt_q;
            end
         end
         DIV_RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!trial_borrow_s) begin
               r_d = trial_s[WIDTH-1:0];
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               r_d = rem_shift_s[WIDTH-1:0];
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
         end
         default: cnt_d = cnt_q;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_q   <= {WIDTH{1'b0}};
         q_q   <= {WIDTH{1'b0}};
         d_q   <= {WIDTH{1'b0}};
         cnt_q <= {CNT_W{1'b0}};
         neg_q <= 1'b0;
      end else begin
         r_q   <= r_d;
         q_q   <= q_d;
         d_q   <= d_d;
         cnt_q <= cnt_d;
         neg_q <= neg_d;
      end
   end

   // FSM outputs: status follows the next state so the ports come straight from flops.
   always_comb begin
      result_d = result_q;
      exc_d    = 1'b0;
      rdy_d    = (state_d == DIV_DONE);
      busy_d   = (state_d == DIV_RUN) || (state_d == DIV_FIX);
      case (state_q)
         DIV_IDLE, DIV_DONE: begin
            if (bus.ctrl_DIV && !b_nonzero_s) begin
               exc_d    = 1'b1;
               result_d = {WIDTH{1'b0}};
            end else begin
               exc_d    = 1'b0;
            end
         end
         DIV_FIX: result_d = neg_q ? neg_a_s[WIDTH-1:0] : q_q;
         default: exc_d = 1'b0;
      endcase
   end

   // Output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         result_q <= {WIDTH{1'b0}};
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         result_q <= result_d;
         exc_q    <= exc_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.data_result    = result_q;
   assign bus.data_exception = exc_q;
   assign bus.data_resultRDY = rdy_q;
   assign bus.busy           = busy_q;

endmodule

// File: tb/tb_div_seq_restoring.sv
// Self-checking bench for div_seq_restoring: scenario tasks plus a scoreboard
// monitor that pops the expected quotient on every ready pulse.
module tb_div_seq_restoring;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   typedef struct packed {
      logic [W-1:0] res;
      logic         exc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   div_seq_restoring_if #(.WIDTH(W)) bus ();

   div_seq_restoring #(.WIDTH(W)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      if (b == 32'd0) begin
         e.res = 32'd0;
         e.exc = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.res = 32'h8000_0000;
         e.exc = 1'b0;
      end else begin
         e.res = $signed(a) / $signed(b);
         e.exc = 1'b0;
      end
      return e;
   endfunction

   // Scoreboard: every ready pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus.data_resultRDY === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_rdy: got result=%h exc=%b, required no ready pulse",
                     bus.data_result, bus.data_exception);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (bus.data_result !== e.res || bus.data_exception !== e.exc) begin
               errors++;
               $display("FAIL sb_result: got result=%h exc=%b, required result=%h exc=%b",
                        bus.data_result, bus.data_exception, e.res, e.exc);
            end
         end
      end
   end

   // Called at a negedge: drive a one-cycle start, then scramble the operands.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
      bus.ctrl_DIV      = 1'b1;
      bus.data_operandA = a;
      bus.data_operandB = b;
      if (push) sb.push_back(model(a, b));
      @(negedge clk);
      bus.ctrl_DIV      = 1'b0;
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
   endtask

   // Count clock edges until ready is seen (bounded).
   task automatic wait_rdy(input int max, output int edges, output bit seen);
      edges = 0;
      seen  = 1'b0;
      while (edges <= max) begin
         if (bus.data_resultRDY === 1'b1) begin
            seen = 1'b1;
            return;
         end
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.ctrl_DIV = 1'b0;
      bus.data_operandA = 32'd0;
      bus.data_operandB = 32'd0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.data_resultRDY !== 1'b0 ||
          bus.data_exception !== 1'b0 || bus.data_result !== 32'd0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b rdy=%b exc=%b result=%h, required all zero",
                  bus.busy, bus.data_resultRDY, bus.data_exception, bus.data_result);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int n;
      bit seen;
      start_op(32'd100, 32'd7, 1'b1);
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy: got %b, required 1", bus.busy);
      end
      wait_rdy(100, n, seen);
      checks++;
      if (!seen || n !== LAT) begin
         errors++;
         $display("FAIL basic_latency: got seen=%b edges=%0d, required edges=%0d", seen, n, LAT);
      end
      @(negedge clk);
      checks++;
      if (bus.data_resultRDY !== 1'b0 || bus.busy !== 1'b0 || bus.data_result !== 32'd14) begin
         errors++;
         $display("FAIL basic_after: got rdy=%b busy=%b result=%h, required 0 0 0000000e",
                  bus.data_resultRDY, bus.busy, bus.data_result);
      end
   endtask

   task automatic test_signs();
      logic [W-1:0] av [3] = '{32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C};
      logic [W-1:0] bv [3] = '{32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
      int n;
      bit seen;
      for (int i = 0; i < 3; i++) begin
         start_op(av[i], bv[i], 1'b1);
         wait_rdy(100, n, seen);
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL signs_timeout: case %0d got no ready, required ready", i);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_div_zero();
      int n;
      bit seen;
      start_op(32'd5, 32'd0, 1'b1);
      wait_rdy(100, n, seen);
      checks++;
      if (!seen || n !== 0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL dz_latency: got seen=%b edges=%0d busy=%b, required edges=0 busy=0",
                  seen, n, bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.data_resultRDY !== 1'b0 || bus.data_exception !== 1'b0) begin
         errors++;
         $display("FAIL dz_clear: got rdy=%b exc=%b, required 0 0",
                  bus.data_resultRDY, bus.data_exception);
      end
      start_op(32'd5, 32'd3, 1'b1);
      wait_rdy(100, n, seen);
      checks++;
      if (!seen || n !== LAT) begin
         errors++;
         $display("FAIL dz_next: got seen=%b edges=%0d, required edges=%0d", seen, n, LAT);
      end
      @(negedge clk);
   endtask

   task automatic test_boundaries();
      logic [W-1:0] av [4] = '{32'h8000_0000, 32'd3, 32'd0, 32'h8000_0000};
      logic [W-1:0] bv [4] = '{32'hFFFF_FFFF, 32'd7, 32'd9, 32'd1};
      int n;
      bit seen;
      for (int i = 0; i < 4; i++) begin
         start_op(av[i], bv[i], 1'b1);
         wait_rdy(100, n, seen);
         checks++;
         if (!seen || n !== LAT) begin
            errors++;
            $display("FAIL bound_latency: case %0d got seen=%b edges=%0d, required %0d",
                     i, seen, n, LAT);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      bit seen;
      start_op(32'd1000, 32'd10, 1'b1);
      repeat (4) @(negedge clk);
      // Start while busy: must be ignored, so nothing is pushed.
      bus.ctrl_DIV      = 1'b1;
      bus.data_operandA = 32'd9;
      bus.data_operandB = 32'd3;
      @(negedge clk);
      bus.ctrl_DIV = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_busy: got %b, required 1", bus.busy);
      end
      wait_rdy(100, n, seen);
      checks++;
      if (!seen || n + 5 !== LAT) begin
         errors++;
         $display("FAIL b2b_first: got seen=%b edges=%0d, required %0d", seen, n + 5, LAT);
      end
      // Restart in the DONE cycle.
      start_op(32'd9, 32'd3, 1'b1);
      wait_rdy(100, n, seen);
      checks++;
      if (!seen || n !== LAT) begin
         errors++;
         $display("FAIL b2b_second: got seen=%b edges=%0d, required %0d", seen, n, LAT);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int n;
      bit seen;
      int rdy_cnt;
      start_op(32'd100, 32'd7, 1'b1);
      repeat (11) @(negedge clk);
      void'(sb.pop_back());
      rst = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.data_resultRDY !== 1'b0 ||
          bus.data_exception !== 1'b0 || bus.data_result !== 32'd0) begin
         errors++;
         $display("FAIL abort_state: got busy=%b rdy=%b exc=%b result=%h, required all zero",
                  bus.busy, bus.data_resultRDY, bus.data_exception, bus.data_result);
      end
      @(negedge clk);
      rst = 1'b0;
      rdy_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.data_resultRDY === 1'b1) rdy_cnt++;
      end
      checks++;
      if (rdy_cnt !== 0) begin
         errors++;
         $display("FAIL abort_rdy: got %0d ready pulses, required 0", rdy_cnt);
      end
      start_op(32'd50, 32'd5, 1'b1);
      wait_rdy(100, n, seen);
      checks++;
      if (!seen || n !== LAT) begin
         errors++;
         $display("FAIL abort_fresh: got seen=%b edges=%0d, required %0d", seen, n, LAT);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [W-1:0] a;
      logic [W-1:0] b;
      int n;
      bit seen;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         case ($urandom_range(0, 2))
            0: b = $urandom;
            1: b = $urandom_range(1, 20);
            default: b = 32'd0 - 32'($urandom_range(1, 300));
         endcase
         if (b == 32'd0) b = 32'd1;
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
         start_op(a, b, 1'b1);
         wait_rdy(100, n, seen);
         checks++;
         if (!seen || n !== LAT) begin
            errors++;
            $display("FAIL rand_latency: a=%h b=%h got seen=%b edges=%0d, required %0d",
                     a, b, seen, n, LAT);
         end
         // Every other operation restarts directly in the DONE cycle.
         if (i % 2 == 0) @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_drain();
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() !== 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d outstanding results, required 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_div_zero();
      test_boundaries();
      test_back_to_back();
      test_reset_abort();
      test_random();
      test_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
